// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: ALU select codes, ALU-op classes,
// funct3/funct7 constants and the ID/EX control bundle.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_MUL = 4'b0100,
    ALU_SUB = 4'b0110
  } alu_sel_e;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_RTYPE = 2'b10,
    ALU_OP_ADD2  = 2'b11
  } alu_op_e;

  localparam logic [2:0] F3_ADD_SUB_MUL = 3'b000;
  localparam logic [2:0] F3_OR          = 3'b110;
  localparam logic [2:0] F3_AND         = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic     valid;
    logic     mem_read;
    logic     mem_write;
    logic     reg_write;
    logic     alu_src;
    alu_sel_e alu_sel;
  } ex_ctrl_t;

  // A bubble clears every control bit; its select encodes as 0000.
  localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
    valid:     1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    reg_write: 1'b0,
    alu_src:   1'b0,
    alu_sel:   ALU_AND
  };

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: ID inputs, forwarding sources, and the EX-side outputs.
interface id_ex_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);

  logic              id_valid;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [1:0]        id_alu_op;
  logic [2:0]        id_funct3;
  logic [6:0]        id_funct7;
  logic              id_alu_src;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_reg_write;
  logic              flush;

  logic [REG_AW-1:0] exm_rd;
  logic              exm_reg_write;
  logic [XLEN-1:0]   exm_result;
  logic [REG_AW-1:0] mwb_rd;
  logic              mwb_reg_write;
  logic [XLEN-1:0]   mwb_result;

  logic              hazard_stall;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [3:0]        alu_sel;
  logic [XLEN-1:0]   ex_store_data;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_reg_write;

  // Upstream pipeline / environment side.
  modport master (
    output id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_funct3, id_funct7, id_alu_src, id_mem_read,
           id_mem_write, id_reg_write, flush,
           exm_rd, exm_reg_write, exm_result, mwb_rd, mwb_reg_write, mwb_result,
    input  hazard_stall, alu_a, alu_b, alu_sel, ex_store_data,
           ex_valid, ex_rd, ex_mem_read, ex_mem_write, ex_reg_write
  );

  // The ID/EX stage itself.
  modport slave (
    input  id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_funct3, id_funct7, id_alu_src, id_mem_read,
           id_mem_write, id_reg_write, flush,
           exm_rd, exm_reg_write, exm_result, mwb_rd, mwb_reg_write, mwb_result,
    output hazard_stall, alu_a, alu_b, alu_sel, ex_store_data,
           ex_valid, ex_rd, ex_mem_read, ex_mem_write, ex_reg_write
  );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Two-source operand forwarding mux: EX/MEM beats MEM/WB, x0 is never forwarded.
module fwd_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   reg_data,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_write,
  input  logic [XLEN-1:0]   exm_result,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic              mwb_reg_write,
  input  logic [XLEN-1:0]   mwb_result,
  output logic [XLEN-1:0]   data
);

  logic exm_hit;
  logic mwb_hit;

  assign exm_hit = exm_reg_write && (exm_rd != '0) && (exm_rd == rs);
  assign mwb_hit = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs);

  always_comb begin
    if (exm_hit)      data = exm_result;
    else if (mwb_hit) data = mwb_result;
    else              data = reg_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands/control, decodes the ALU select,
// forwards from EX/MEM and MEM/WB, and stalls decode on a load-use hazard.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input logic  clk,
  input logic  reset,
  id_ex_if.slave bus
);

  ex_ctrl_t          ctrl_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [XLEN-1:0]   rs1_data_q;
  logic [XLEN-1:0]   rs2_data_q;
  logic [XLEN-1:0]   imm_q;

  alu_sel_e          sel_d;
  logic              bubble;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_d = ALU_ADD;
    unique case (alu_op_e'(bus.id_alu_op))
      ALU_OP_SUB: sel_d = ALU_SUB;
      ALU_OP_RTYPE: begin
        if (bus.id_funct3 == F3_AND)     sel_d = ALU_AND;
        else if (bus.id_funct3 == F3_OR) sel_d = ALU_OR;
        else if (bus.id_funct3 == F3_ADD_SUB_MUL) begin
          if (bus.id_funct7 == F7_ALT)         sel_d = ALU_SUB;
          else if (bus.id_funct7 == F7_MULDIV) sel_d = ALU_MUL;
          else                                 sel_d = ALU_ADD;
        end
      end
      default: sel_d = ALU_ADD;
    endcase
  end

  // A load in EX whose rd feeds the instruction in ID cannot be forwarded yet.
  assign bus.hazard_stall = ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0) &&
                            bus.id_valid &&
                            ((rd_q == bus.id_rs1) || (rd_q == bus.id_rs2));

  assign bubble = bus.flush || bus.hazard_stall;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= EX_CTRL_BUBBLE;
    end else if (bubble) begin
      ctrl_q <= EX_CTRL_BUBBLE;
    end else begin
      ctrl_q <= '{
        valid:     bus.id_valid,
        mem_read:  bus.id_mem_read,
        mem_write: bus.id_mem_write,
        reg_write: bus.id_reg_write,
        alu_src:   bus.id_alu_src,
        alu_sel:   sel_d
      };
    end
  end

  // Data fields hold through a bubble; only a real capture replaces them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else if (!bubble) begin
      rd_q       <= bus.id_rd;
      rs1_q      <= bus.id_rs1;
      rs2_q      <= bus.id_rs2;
      rs1_data_q <= bus.id_rs1_data;
      rs2_data_q <= bus.id_rs2_data;
      imm_q      <= bus.id_imm;
    end
  end

  fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs            (rs1_q),
    .reg_data      (rs1_data_q),
    .exm_rd        (bus.exm_rd),
    .exm_reg_write (bus.exm_reg_write),
    .exm_result    (bus.exm_result),
    .mwb_rd        (bus.mwb_rd),
    .mwb_reg_write (bus.mwb_reg_write),
    .mwb_result    (bus.mwb_result),
    .data          (fwd_rs1)
  );

  fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs            (rs2_q),
    .reg_data      (rs2_data_q),
    .exm_rd        (bus.exm_rd),
    .exm_reg_write (bus.exm_reg_write),
    .exm_result    (bus.exm_result),
    .mwb_rd        (bus.mwb_rd),
    .mwb_reg_write (bus.mwb_reg_write),
    .mwb_result    (bus.mwb_result),
    .data          (fwd_rs2)
  );

  assign bus.alu_a         = fwd_rs1;
  assign bus.alu_b         = ctrl_q.alu_src ? imm_q : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.alu_sel       = ctrl_q.alu_sel;
  assign bus.ex_valid      = ctrl_q.valid;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.ex_reg_write  = ctrl_q.reg_write;

endmodule
